// File: rtl/syn_fifo_prm.sv
// syn_fifo_prm: parametrised single-clock FIFO with register-array storage.
//   Read mode is selectable: registered read (FWFT=0) or first-word-fall-through
//   (FWFT=1). Reports the fill level, almost-full/almost-empty thresholds and
//   sticky overflow/underflow flags. A synchronous flush clears the FIFO.
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   flush            synchronous clear of pointers, level, error flags, data_out
//   wr_en, data_in   write request and write data
//   rd_en            read/pop request
//   data_out         read data (timing depends on FWFT)
//   full, empty      level == DEPTH / level == 0
//   almost_full      level >= AF_THRESH
//   almost_empty     level <= AE_THRESH
//   level            stored word count, 0..DEPTH
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
module syn_fifo_prm #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);

  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("syn_fifo_prm: AF_THRESH %0d outside 1..%0d", AF_THRESH, DEPTH);
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("syn_fifo_prm: AE_THRESH %0d outside 0..%0d", AE_THRESH, DEPTH - 1);
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ok, rd_ok;

  // Acceptance uses the registered flags, i.e. the state before the edge.
  assign wr_ok = wr_en & ~full_q;
  assign rd_ok = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      dout_d   = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (wr_en & full_q);
      unf_d = unf_q | (rd_en & empty_q);
    end
    // Flags are registered from the post-edge level so they line up with level.
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
    af_d    = (level_d >= AF_L);
    ae_d    = (level_d <= AE_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  // Storage has no reset; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = (FWFT != 0) ? (empty_q ? '0 : mem_q[rd_ptr_q]) : dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
